// File: rtl/uart_cmd_parser_if.sv
// ============================================================================
// Module      : uart_cmd_parser_if
// Description : Single-word bus request/response channel between the command
//               parser and the AXI-Lite master stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface uart_cmd_parser_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic [1:0]  rsp_resp;

   modport master (
      output req_valid, req_write, req_addr, req_wdata,
      input  req_ready, rsp_valid, rsp_rdata, rsp_resp
   );

   modport slave (
      input  req_valid, req_write, req_addr, req_wdata,
      output req_ready, rsp_valid, rsp_rdata, rsp_resp
   );
endinterface

`default_nettype wire

// File: rtl/uart_cmd_parser.sv
// ============================================================================
// Module      : uart_cmd_parser
// Description : Turns a UART byte stream into single-word bus requests and
//               serializes read data back to the transmitter, LSB first.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_cmd_parser #(
   parameter int unsigned TIMEOUT_CYC = 1_000_000
) (
   input  wire logic               clk,
   input  wire logic               rst,
   input  wire logic               rx_valid,
   input  wire logic [7:0]         rx_data,
   input  wire logic               rx_err,
   uart_cmd_parser_if.master       bus,
   output logic                    tx_act,
   output logic [7:0]              tx_data,
   input  wire logic               tx_busy,
   output logic                    busy,
   output logic [1:0]              err_code
);

   localparam int unsigned        CNT_W    = $clog2(TIMEOUT_CYC + 1);
   localparam logic [CNT_W-1:0]   TMO_LAST = CNT_W'(TIMEOUT_CYC - 1);
   localparam logic [1:0]         OP_WRITE = 2'b01;
   localparam logic [1:0]         OP_READ  = 2'b10;
   localparam logic [1:0]         ERR_NONE = 2'd0;
   localparam logic [1:0]         ERR_RX   = 2'd1;
   localparam logic [1:0]         ERR_OVR  = 2'd2;
   localparam logic [1:0]         ERR_RESP = 2'd3;

   typedef enum logic [3:0] {
      S_IDLE  = 4'd0,
      S_ADDR  = 4'd1,
      S_WDATA = 4'd2,
      S_WREQ  = 4'd3,
      S_WRSP  = 4'd4,
      S_RREQ  = 4'd5,
      S_RRSP  = 4'd6,
      S_TXB   = 4'd7,
      S_TXW   = 4'd8
   } state_t;

   state_t            r_state,      w_state;
   logic              r_is_write,   w_is_write;
   logic [5:0]        r_words_left, w_words_left;
   logic [1:0]        r_byte_idx,   w_byte_idx;
   logic [31:0]       r_addr,       w_addr;
   logic [31:0]       r_wshift,     w_wshift;
   logic [31:0]       r_rdata,      w_rdata;
   logic [CNT_W-1:0]  r_tmo_cnt,    w_tmo_cnt;
   logic              r_seen_busy,  w_seen_busy;
   logic              r_req_valid,  w_req_valid;
   logic              r_req_write,  w_req_write;
   logic [31:0]       r_req_addr,   w_req_addr;
   logic [31:0]       r_req_wdata,  w_req_wdata;
   logic              r_tx_act,     w_tx_act;
   logic [7:0]        r_tx_data,    w_tx_data;
   logic              r_busy,       w_busy;
   logic [1:0]        r_err,        w_err;

   logic              w_in_frame;
   logic              w_rx_open;
   logic              w_timeout;
   logic              w_rsp_take;

   assign w_in_frame = (r_state == S_ADDR) || (r_state == S_WDATA);
   assign w_rx_open  = w_in_frame || (r_state == S_IDLE);
   assign w_timeout  = w_in_frame && !rx_valid && (r_tmo_cnt == TMO_LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_is_write   <= 1'b0;
         r_words_left <= '0;
         r_byte_idx   <= '0;
         r_addr       <= '0;
         r_wshift     <= '0;
         r_rdata      <= '0;
         r_tmo_cnt    <= '0;
         r_seen_busy  <= 1'b0;
         r_req_valid  <= 1'b0;
         r_req_write  <= 1'b0;
         r_req_addr   <= '0;
         r_req_wdata  <= '0;
         r_tx_act     <= 1'b0;
         r_tx_data    <= '0;
         r_busy       <= 1'b0;
         r_err        <= ERR_NONE;
      end else begin
         r_state      <= w_state;
         r_is_write   <= w_is_write;
         r_words_left <= w_words_left;
         r_byte_idx   <= w_byte_idx;
         r_addr       <= w_addr;
         r_wshift     <= w_wshift;
         r_rdata      <= w_rdata;
         r_tmo_cnt    <= w_tmo_cnt;
         r_seen_busy  <= w_seen_busy;
         r_req_valid  <= w_req_valid;
         r_req_write  <= w_req_write;
         r_req_addr   <= w_req_addr;
         r_req_wdata  <= w_req_wdata;
         r_tx_act     <= w_tx_act;
         r_tx_data    <= w_tx_data;
         r_busy       <= w_busy;
         r_err        <= w_err;
      end
   end

   always_comb begin
      w_state      = r_state;
      w_is_write   = r_is_write;
      w_words_left = r_words_left;
      w_byte_idx   = r_byte_idx;
      w_addr       = r_addr;
      w_wshift     = r_wshift;
      w_rdata      = r_rdata;
      w_seen_busy  = r_seen_busy;
      w_err        = r_err;
      w_rsp_take   = 1'b0;
      w_tmo_cnt    = (w_in_frame && !rx_valid) ? r_tmo_cnt + CNT_W'(1) : '0;

      case (r_state)
         S_IDLE: begin
            if (rx_valid && (rx_data[7:6] == OP_WRITE || rx_data[7:6] == OP_READ)) begin
               w_is_write   = (rx_data[7:6] == OP_WRITE);
               w_words_left = rx_data[5:0];
               w_byte_idx   = 2'd0;
               w_err        = ERR_NONE;
               w_state      = S_ADDR;
            end
         end
         S_ADDR: begin
            if (rx_err || w_timeout) begin
               w_err   = ERR_RX;
               w_state = S_IDLE;
            end else if (rx_valid) begin
               w_addr     = {rx_data, r_addr[31:8]};
               w_byte_idx = r_byte_idx + 2'd1;
               if (r_byte_idx == 2'd3)
                  w_state = r_is_write ? S_WDATA : S_RREQ;
            end
         end
         S_WDATA: begin
            if (rx_err || w_timeout) begin
               w_err   = ERR_RX;
               w_state = S_IDLE;
            end else if (rx_valid) begin
               w_wshift   = {rx_data, r_wshift[31:8]};
               w_byte_idx = r_byte_idx + 2'd1;
               if (r_byte_idx == 2'd3)
                  w_state = S_WREQ;
            end
         end
         S_WREQ: begin
            if (bus.req_ready) begin
               w_addr     = r_addr + 32'd4;
               w_state    = S_WRSP;
               w_rsp_take = bus.rsp_valid;
            end
         end
         S_WRSP: w_rsp_take = bus.rsp_valid;
         S_RREQ: begin
            if (bus.req_ready) begin
               w_addr     = r_addr + 32'd4;
               w_state    = S_RRSP;
               w_rsp_take = bus.rsp_valid;
            end
         end
         S_RRSP: w_rsp_take = bus.rsp_valid;
         S_TXB: begin
            w_seen_busy = 1'b0;
            w_state     = S_TXW;
         end
         S_TXW: begin
            // A byte is complete only after busy has been seen high and then low
            if (tx_busy) begin
               w_seen_busy = 1'b1;
            end else if (r_seen_busy) begin
               w_byte_idx = r_byte_idx + 2'd1;
               if (r_byte_idx != 2'd3) begin
                  w_state = S_TXB;
               end else if (r_words_left != 6'd0) begin
                  w_words_left = r_words_left - 6'd1;
                  w_state      = S_RREQ;
               end else begin
                  w_state = S_IDLE;
               end
            end
         end
         default: w_state = S_IDLE;
      endcase

      if (rx_valid && !w_rx_open)
         w_err = ERR_OVR;

      if (w_rsp_take) begin
         if (bus.rsp_resp != 2'd0)
            w_err = ERR_RESP;
         if (r_is_write) begin
            if (r_words_left != 6'd0) begin
               w_words_left = r_words_left - 6'd1;
               w_state      = S_WDATA;
            end else begin
               w_state = S_IDLE;
            end
         end else begin
            w_rdata    = bus.rsp_rdata;
            w_byte_idx = 2'd0;
            w_state    = S_TXB;
         end
      end

      // Outputs are computed from the next state so they come straight from flops
      w_req_valid = (w_state == S_WREQ) || (w_state == S_RREQ);
      w_req_write = (w_state == S_WREQ) ? 1'b1 :
                    (w_state == S_RREQ) ? 1'b0 : r_req_write;
      w_req_addr  = w_req_valid ? w_addr : r_req_addr;
      w_req_wdata = (w_state == S_WREQ) ? w_wshift : r_req_wdata;
      w_tx_act    = (w_state == S_TXB);
      w_tx_data   = (w_state == S_TXB) ? w_rdata[{w_byte_idx, 3'b000} +: 8] : r_tx_data;
      w_busy      = (w_state != S_IDLE);
   end

   assign bus.req_valid = r_req_valid;
   assign bus.req_write = r_req_write;
   assign bus.req_addr  = r_req_addr;
   assign bus.req_wdata = r_req_wdata;
   assign tx_act        = r_tx_act;
   assign tx_data       = r_tx_data;
   assign busy          = r_busy;
   assign err_code      = r_err;

endmodule

`default_nettype wire

// File: tb/tb_uart_cmd_parser.sv
// ============================================================================
// Module      : tb_uart_cmd_parser
// Description : Scoreboard bench for uart_cmd_parser with bus-slave and
//               uart_tx stand-ins.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_cmd_parser;
   logic       clk = 1'b0;
   logic       rst;
   logic       rx_valid;
   logic [7:0] rx_data;
   logic       rx_err;
   logic       tx_act;
   logic [7:0] tx_data;
   logic       tx_busy;
   logic       busy;
   logic [1:0] err_code;

   uart_cmd_parser_if bus ();

   uart_cmd_parser #(.TIMEOUT_CYC(100)) dut (
      .clk      (clk),
      .rst      (rst),
      .rx_valid (rx_valid),
      .rx_data  (rx_data),
      .rx_err   (rx_err),
      .bus      (bus),
      .tx_act   (tx_act),
      .tx_data  (tx_data),
      .tx_busy  (tx_busy),
      .busy     (busy),
      .err_code (err_code)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        wr;
      logic [31:0] addr;
      logic [31:0] data;
   } req_t;

   req_t        req_q[$];
   logic [7:0]  tx_q[$];
   logic [31:0] mem [logic [31:0]];
   int          n_cmp = 0;
   int          n_fail = 0;
   int          req_cnt = 0;
   int          rsp_cnt = 0;
   int          txa_cnt = 0;
   logic [1:0]  resp_code = 2'd0;
   bit          same_cycle = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Bus slave: accepts each request one negedge after it appears, then responds
   initial begin
      bus.req_ready = 1'b0;
      bus.rsp_valid = 1'b0;
      bus.rsp_rdata = '0;
      bus.rsp_resp  = '0;
      forever begin
         @(negedge clk);
         if (bus.req_valid && !rst) begin
            req_t        e;
            logic [31:0] rd;
            req_cnt++;
            if (req_q.size() == 0) begin
               n_cmp++;
               n_fail++;
               $display("FAIL unexpected_req: got addr 0x%08h expected no request", bus.req_addr);
            end else begin
               e = req_q.pop_front();
               chk("req_write", bus.req_write, e.wr);
               chk("req_addr", bus.req_addr, e.addr);
               if (e.wr)
                  chk("req_wdata", bus.req_wdata, e.data);
            end
            rd = mem.exists(bus.req_addr) ? mem[bus.req_addr] : 32'h0;
            if (bus.req_write)
               mem[bus.req_addr] = bus.req_wdata;
            bus.req_ready = 1'b1;
            if (same_cycle) begin
               bus.rsp_valid = 1'b1;
               bus.rsp_rdata = rd;
               bus.rsp_resp  = resp_code;
               rsp_cnt++;
            end
            @(negedge clk);
            bus.req_ready = 1'b0;
            chk("req_valid_drop", bus.req_valid, 0);
            if (!same_cycle) begin
               bus.rsp_valid = 1'b1;
               bus.rsp_rdata = rd;
               bus.rsp_resp  = resp_code;
               rsp_cnt++;
               @(negedge clk);
            end
            bus.rsp_valid = 1'b0;
            bus.rsp_resp  = 2'd0;
         end
      end
   end

   // uart_tx stand-in: busy for a few cycles after each start strobe
   initial begin
      tx_busy = 1'b0;
      forever begin
         @(negedge clk);
         if (tx_act && !rst) begin
            logic [7:0] held;
            txa_cnt++;
            held = tx_data;
            if (tx_q.size() == 0) begin
               n_cmp++;
               n_fail++;
               $display("FAIL unexpected_tx: got 0x%02h expected no byte", tx_data);
            end else begin
               chk("tx_byte", tx_data, tx_q.pop_front());
            end
            tx_busy = 1'b1;
            @(negedge clk);
            chk("tx_act_pulse", tx_act, 0);
            repeat (4) begin
               @(negedge clk);
               if (rst) break;
            end
            if (!rst)
               chk("tx_data_hold", tx_data, held);
            tx_busy = 1'b0;
         end
      end
   end

   task automatic send_byte(input logic [7:0] b, input int gap);
      @(posedge clk);
      #1;
      rx_valid = 1'b1;
      rx_data  = b;
      @(posedge clk);
      #1;
      rx_valid = 1'b0;
      repeat (gap) @(posedge clk);
   endtask

   task automatic send_word(input logic [31:0] w);
      send_byte(w[7:0], 10);
      send_byte(w[15:8], 10);
      send_byte(w[23:16], 10);
      send_byte(w[31:24], 10);
   endtask

   task automatic push_req(input logic wr, input logic [31:0] a, input logic [31:0] d);
      req_t e;
      e.wr   = wr;
      e.addr = a;
      e.data = d;
      req_q.push_back(e);
   endtask

   task automatic push_tx_word(input logic [31:0] w);
      tx_q.push_back(w[7:0]);
      tx_q.push_back(w[15:8]);
      tx_q.push_back(w[23:16]);
      tx_q.push_back(w[31:24]);
   endtask

   task automatic wait_idle(input string name);
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         if (!busy) break;
      end
      chk(name, busy, 0);
   endtask

   task automatic wait_tx(input int target);
      for (int i = 0; i < 1000; i++) begin
         @(negedge clk);
         if (txa_cnt >= target) break;
      end
      chk("wait_tx_count", (txa_cnt >= target), 1);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_req_valid"}, bus.req_valid, 0);
      chk({tag, "_req_write"}, bus.req_write, 0);
      chk({tag, "_req_addr"},  bus.req_addr, 0);
      chk({tag, "_req_wdata"}, bus.req_wdata, 0);
      chk({tag, "_tx_act"},    tx_act, 0);
      chk({tag, "_tx_data"},   tx_data, 0);
      chk({tag, "_busy"},      busy, 0);
      chk({tag, "_err_code"},  err_code, 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got no finish expected finish before time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [7:0] t2_bytes [12];
      int r0, c0, t0, t1, c1;
      t2_bytes = '{8'h44, 8'h33, 8'h22, 8'h11, 8'hA5, 8'hA5, 8'hA5, 8'hA5,
                   8'h01, 8'h00, 8'h00, 8'h00};
      rx_valid = 1'b0;
      rx_data  = 8'h00;
      rx_err   = 1'b0;
      rst      = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_reset_outputs("reset");
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Three-word write
      push_req(1'b1, 32'h44A00000, 32'h11223344);
      push_req(1'b1, 32'h44A00004, 32'hA5A5A5A5);
      push_req(1'b1, 32'h44A00008, 32'h00000001);
      r0 = rsp_cnt;
      send_byte(8'h42, 10);
      @(negedge clk);
      chk("t1_busy_high", busy, 1);
      send_word(32'h44A00000);
      send_word(32'h11223344);
      send_word(32'hA5A5A5A5);
      send_word(32'h00000001);
      wait_idle("t1_busy_fall");
      chk("t1_rsp_count", rsp_cnt - r0, 3);
      chk("t1_err", err_code, 0);

      // Three-word read of the same locations
      push_req(1'b0, 32'h44A00000, 32'h0);
      push_req(1'b0, 32'h44A00004, 32'h0);
      push_req(1'b0, 32'h44A00008, 32'h0);
      foreach (t2_bytes[i]) tx_q.push_back(t2_bytes[i]);
      send_byte(8'h82, 10);
      send_word(32'h44A00000);
      wait_idle("t2_idle");
      chk("t2_err", err_code, 0);
      chk("t2_tx_left", tx_q.size(), 0);
      chk("t2_req_left", req_q.size(), 0);

      // Ignored opcodes
      c0 = req_cnt;
      send_byte(8'h00, 2);
      @(negedge clk);
      chk("t3_busy_after_00", busy, 0);
      send_byte(8'hC1, 2);
      @(negedge clk);
      chk("t3_busy_after_c1", busy, 0);
      repeat (20) @(posedge clk);
      chk("t3_no_req", req_cnt - c0, 0);

      // Address wrap across 2^32
      push_req(1'b1, 32'hFFFFFFFC, 32'h0BADF00D);
      push_req(1'b1, 32'h00000000, 32'h76543210);
      send_byte(8'h41, 10);
      send_word(32'hFFFFFFFC);
      send_word(32'h0BADF00D);
      send_word(32'h76543210);
      wait_idle("t4_idle");
      chk("t4_req_left", req_q.size(), 0);

      // Framing error mid-address aborts the frame
      send_byte(8'h40, 3);
      send_byte(8'h00, 3);
      @(posedge clk);
      #1;
      rx_err = 1'b1;
      @(posedge clk);
      #1;
      rx_err = 1'b0;
      @(negedge clk);
      chk("rxerr_busy", busy, 0);
      chk("rxerr_err", err_code, 1);

      // Inter-byte timeout of 100 cycles
      send_byte(8'h40, 0);
      send_byte(8'h00, 0);
      send_byte(8'h01, 0);
      repeat (94) @(posedge clk);
      @(negedge clk);
      chk("tmo_early_busy", busy, 1);
      chk("tmo_early_err", err_code, 0);
      repeat (10) @(posedge clk);
      @(negedge clk);
      chk("tmo_busy", busy, 0);
      chk("tmo_err", err_code, 1);

      push_req(1'b1, 32'h00000010, 32'hCAFEF00D);
      send_byte(8'h40, 10);
      send_word(32'h00000010);
      send_word(32'hCAFEF00D);
      wait_idle("tmo_next_idle");
      chk("tmo_next_err", err_code, 0);
      chk("tmo_next_req_left", req_q.size(), 0);

      // Byte arriving during transmit is an overrun; frame still completes
      push_req(1'b0, 32'h44A00004, 32'h0);
      push_tx_word(32'hA5A5A5A5);
      t0 = txa_cnt;
      send_byte(8'h80, 10);
      send_word(32'h44A00004);
      wait_tx(t0 + 1);
      send_byte(8'h55, 0);
      wait_idle("ovr_idle");
      chk("ovr_err", err_code, 2);
      chk("ovr_tx_left", tx_q.size(), 0);

      // Error response with same-cycle completion
      resp_code  = 2'd2;
      same_cycle = 1'b1;
      push_req(1'b0, 32'h00000010, 32'h0);
      tx_q.push_back(8'h0D);
      tx_q.push_back(8'hF0);
      tx_q.push_back(8'hFE);
      tx_q.push_back(8'hCA);
      send_byte(8'h80, 10);
      send_word(32'h00000010);
      wait_idle("resp_idle");
      chk("resp_err", err_code, 3);
      chk("resp_tx_left", tx_q.size(), 0);
      resp_code  = 2'd0;
      same_cycle = 1'b0;

      // Reset while waiting on the transmitter
      push_req(1'b0, 32'h44A00000, 32'h0);
      push_req(1'b0, 32'h44A00004, 32'h0);
      push_tx_word(32'h11223344);
      push_tx_word(32'hA5A5A5A5);
      t0 = txa_cnt;
      send_byte(8'h81, 10);
      send_word(32'h44A00000);
      wait_tx(t0 + 2);
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      tx_q.delete();
      req_q.delete();
      @(negedge clk);
      chk_reset_outputs("rst_mid");
      t1 = txa_cnt;
      c1 = req_cnt;
      repeat (60) @(negedge clk);
      chk("rst_no_tx", txa_cnt - t1, 0);
      chk("rst_no_req", req_cnt - c1, 0);
      chk("rst_busy", busy, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/uart_cmd_parser.md
# uart_cmd_parser

Byte-level command parser between `uart_rx` and the AXI-Lite master stage of the UART-to-AXI bridge. It assembles a command byte, a 32-bit address and optional write words from the received byte stream. It issues one single-word bus request per word through a valid/ready handshake. For reads, it serializes each returned word back to `uart_tx` as four bytes, LSB first.

## Interface
Parameters:
- `TIMEOUT_CYC`, default 1_000_000: idle clocks allowed between bytes inside a frame before abort.

Ports:
- `clk` in 1: single clock; all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `rx_valid` in 1: one-cycle strobe, `rx_data` valid.
- `rx_data` in 8: received byte.
- `rx_err` in 1: one-cycle framing-error strobe from `uart_rx`.
- `req_valid` out 1: bus request valid.
- `req_ready` in 1: request accepted when `req_valid & req_ready`.
- `req_write` out 1: 1 = write, 0 = read.
- `req_addr` out 32: word address.
- `req_wdata` out 32: write data.
- `rsp_valid` in 1: one-cycle completion strobe for the outstanding request.
- `rsp_rdata` in 32: read data, valid with `rsp_valid`.
- `rsp_resp` in 2: AXI response code, valid with `rsp_valid`.
- `tx_act` out 1: one-cycle start strobe to `uart_tx`.
- `tx_data` out 8: byte to transmit; held stable from `tx_act` until the byte completes.
- `tx_busy` in 1: `uart_tx` busy.
- `busy` out 1: high whenever the FSM is not in IDLE.
- `err_code` out 2: sticky last error. 0 none, 1 timeout/`rx_err`, 2 overrun, 3 bad response.

## Operation
- Command byte: [7:6] is the opcode, 01 = write, 10 = read; 00 and 11 are ignored and the FSM stays in IDLE. [5:0] is N, where word count = N+1 (1..64).
- Frame format: command, then 4 address bytes LSB first. A write frame follows with (N+1)×4 data bytes, each word LSB first. A read frame has no further bytes.
- Word i is addressed at base + 4·i, modulo 2^32 (wraps, no error). Address bits [1:0] are passed through unchanged.
- A valid command byte clears `err_code` to 0.
- States:
  - IDLE: wait for a valid command byte; latch op and N → ADDR.
  - ADDR: 4 bytes. Then write → WDATA; read → RREQ.
  - WDATA: 4 bytes → WREQ.
  - WREQ: hold `req_valid`, `req_write`=1 until accepted → WRSP.
  - WRSP: wait `rsp_valid`. If words remain → WDATA, else → IDLE.
  - RREQ: hold `req_valid`, `req_write`=0 until accepted → RRSP.
  - RRSP: on `rsp_valid`, latch `rsp_rdata` → TXB.
  - TXB: pulse `tx_act` → TXW.
  - TXW: wait for `tx_busy` high, then low. If bytes of the word remain → TXB. Otherwise, if words remain → RREQ, else → IDLE.
- Only one request is outstanding at a time.
- `rsp_resp` ≠ 0: set `err_code`=3 and continue. Read data is still transmitted as returned.
- Bytes are accepted only in IDLE, ADDR and WDATA. An `rx_valid` in any other state drops the byte and sets `err_code`=2; the frame continues.
- `rx_err` in ADDR or WDATA, or a timeout: set `err_code`=1, discard the partial frame → IDLE. `rx_err` in IDLE is ignored.
- Timeout counter: reset on each accepted byte; counts only in ADDR and WDATA. Abort occurs when the count reaches `TIMEOUT_CYC`.

## Timing
- Reset values: state IDLE; `req_valid`=0, `req_write`=0, `req_addr`=0, `req_wdata`=0, `tx_act`=0, `tx_data`=0, `busy`=0, `err_code`=0.
- All outputs are registered.
- `req_valid` rises the cycle after the 4th byte of a word (write) or the last address byte / last TXW exit (read).
- `req_*` stay stable until the handshake completes; `req_valid` deasserts the cycle after acceptance.
- `rsp_valid` arriving in the same cycle as acceptance is legal; the FSM takes it and skips waiting in WRSP/RRSP.
- `tx_act` is high for exactly one cycle.
- The next `tx_act` comes no earlier than 1 cycle after the observed `tx_busy` falling edge.
- `rst` has priority over everything in any state, including mid-request and mid-transmit. The next cycle is IDLE with all outputs at reset values, and no further request or tx byte is issued.

## Test plan
- Write 0x42, addr 0x44A00000, words 0x11223344, 0xA5A5A5A5, 0x00000001 → three write requests at 0x44A00000/04/08 with those data. `busy` falls after the 3rd `rsp_valid`; `err_code`=0.
- Read 0x82 at 0x44A00000 with memory returning the above → 12 tx bytes in order 44 33 22 11 A5 A5 A5 A5 01 00 00 00.
- Command 0x00, then 0xC1 → no request; `busy` stays 0.
- Write 0x40, addr 0xFFFFFFFC with N=1 (0x41) → requests at 0xFFFFFFFC and then 0x00000000.
- `TIMEOUT_CYC`=100, send 0x40 plus 2 address bytes, then idle → `err_code`=1 at cycle 100, IDLE. A following valid frame executes normally.
- `rsp_resp`=2 on a read → `err_code`=3, bytes still sent. `rst` pulse during TXW → no further `tx_act`, all outputs at reset values.
